// File: rtl/alu_seq.sv
// alu_seq: WIDTH-generic handshaked ALU with registered result
// and a multi-cycle shift-add unsigned multiplier.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int OPW   = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] InputA,
    input  logic [WIDTH-1:0] InputB,
    input  logic [OPW-1:0]   OP,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] Out,
    output logic [WIDTH-1:0] OutHi,
    output logic             Zero,
    output logic             Carry,
    output logic             Busy
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    localparam logic [OPW-1:0] OP_ADD  = OPW'(0);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(1);
    localparam logic [OPW-1:0] OP_AND  = OPW'(2);
    localparam logic [OPW-1:0] OP_XOR  = OPW'(3);
    localparam logic [OPW-1:0] OP_RXOR = OPW'(4);
    localparam logic [OPW-1:0] OP_LSH  = OPW'(5);
    localparam logic [OPW-1:0] OP_RSH  = OPW'(6);
    localparam logic [OPW-1:0] OP_SEQ  = OPW'(7);
    localparam logic [OPW-1:0] OP_SLT  = OPW'(8);
    localparam logic [OPW-1:0] OP_MUL  = OPW'(9);

    localparam logic [WIDTH-1:0] WLIM = WIDTH'(WIDTH);

    logic [0:0]         state;
    logic               out_valid;
    logic [WIDTH-1:0]   out_lo;
    logic [WIDTH-1:0]   out_hi;
    logic               zero;
    logic               carry;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;

    logic               accept;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_carry;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;

    assign InReady  = (state == S_IDLE) && (!out_valid || OutReady);
    assign accept   = InValid && InReady;
    assign OutValid = out_valid;
    assign Out      = out_lo;
    assign OutHi    = out_hi;
    assign Zero     = zero;
    assign Carry    = carry;
    assign Busy     = (state == S_BUSY);

    assign sum  = {1'b0, InputA} + {1'b0, InputB};
    assign diff = {1'b0, InputA} - {1'b0, InputB};

    // one shift-add step: add the shifted multiplicand when the
    // current multiplier LSB is set
    assign acc_next = acc + (mplier[0] ? mcand : '0);

    // single-cycle result computed from the live inputs at accept
    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        case (OP)
            OP_ADD: begin
                alu_res   = sum[WIDTH-1:0];
                alu_carry = sum[WIDTH];
            end
            OP_SUB: begin
                alu_res   = diff[WIDTH-1:0];
                alu_carry = diff[WIDTH];
            end
            OP_AND:  alu_res = InputA & InputB;
            OP_XOR:  alu_res = InputA ^ InputB;
            OP_RXOR: alu_res = {{(WIDTH-1){1'b0}}, ^InputA};
            OP_LSH:  alu_res = (InputB >= WLIM) ? '0 : (InputA << InputB);
            OP_RSH:  alu_res = (InputB >= WLIM) ? '0 : (InputA >> InputB);
            OP_SEQ:  alu_res = {{(WIDTH-1){1'b0}}, InputA == InputB};
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}},
                                $signed(InputA) < $signed(InputB)};
            default: begin
                alu_res   = '0;
                alu_carry = 1'b0;
            end
        endcase
    end

    // handshake, result registers and multiply sequencing
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            out_lo    <= '0;
            out_hi    <= '0;
            zero      <= 1'b1;
            carry     <= 1'b0;
            cnt       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
        end else begin
            if (out_valid && OutReady) begin
                out_valid <= 1'b0;
            end
            if (state == S_IDLE) begin
                if (accept) begin
                    if (OP == OP_MUL) begin
                        state     <= S_BUSY;
                        cnt       <= '0;
                        mcand     <= {{WIDTH{1'b0}}, InputA};
                        mplier    <= InputB;
                        acc       <= '0;
                        out_valid <= 1'b0;
                    end else begin
                        out_lo    <= alu_res;
                        out_hi    <= '0;
                        zero      <= (alu_res == '0);
                        carry     <= alu_carry;
                        out_valid <= 1'b1;
                    end
                end
            end else begin
                acc    <= acc_next;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + CW'(1);
                if (cnt == CW'(WIDTH - 1)) begin
                    out_lo    <= acc_next[WIDTH-1:0];
                    out_hi    <= acc_next[2*WIDTH-1:WIDTH];
                    zero      <= (acc_next[WIDTH-1:0] == '0);
                    carry     <= 1'b0;
                    out_valid <= 1'b1;
                    state     <= S_IDLE;
                end
            end
        end
    end

endmodule
